// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency, big-endian word
// memory between an instruction-fetch requester (I) and a data load/store
// requester (D). At most one request is granted per cycle. The granted
// request drives the memory port in the same cycle. Reads are tagged with
// their source so that returned words go back to the requester that issued
// them.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate I/D on a tie.
// Without it, D always wins a tie.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   IReq/IAddr/IGnt            instruction read request, address, grant
//   IRdValid/IRdData           instruction read return
//   DReq/DWe/DAddr/DSize/DWdata  data request (load/store), size, store data
//   DGnt                       data grant
//   DRdValid/DRdData           data read return (raw 32-bit word)
//   DErr                       pulse: misaligned/illegal D request was dropped
//   MemEn/MemWe/MemAddr/MemWdata  memory request port
//   MemRdata                   memory read data, READ_LATENCY cycles after enable edge
module mem_port_arbiter #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic              IGnt,
  output logic              IRdValid,
  output logic [31:0]       IRdData,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [1:0]        DSize,
  input  logic [31:0]       DWdata,
  output logic              DGnt,
  output logic              DRdValid,
  output logic [31:0]       DRdData,
  output logic              DErr,
  output logic              MemEn,
  output logic [3:0]        MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWdata,
  input  logic [31:0]       MemRdata
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_e;

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  src_e                     last_gnt;
  src_e                     last_gnt_nxt;
  logic                     tie_to_d;
  logic                     d_mis;
  logic [3:0]               st_be;
  logic [DATA_W-1:0]        st_data;
  logic                     push_vld;
  logic                     push_src;
  logic [READ_LATENCY-1:0]  tag_vld;
  logic [READ_LATENCY-1:0]  tag_src;
  logic                     tail_vld;
  logic                     tail_src;
  logic [DATA_W-1:0]        i_hold;
  logic [DATA_W-1:0]        d_hold;

  // Tie-break policy
`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign tie_to_d = (last_gnt == SRC_I);
`else
  assign tie_to_d = 1'b1;
`endif

  assign DGnt = DReq & (~IReq | tie_to_d);
  assign IGnt = IReq & ~DGnt;

  // Alignment check and store lane mapping for the D request
  always_comb begin
    d_mis   = 1'b0;
    st_be   = 4'b0000;
    st_data = '0;
    case (DSize)
      2'b00: begin
        st_be   = 4'b1000 >> DAddr[1:0];
        st_data = {4{DWdata[7:0]}};
      end
      2'b01: begin
        d_mis   = DAddr[0];
        st_be   = DAddr[1] ? 4'b0011 : 4'b1100;
        st_data = {2{DWdata[15:0]}};
      end
      2'b11: begin
        d_mis   = (DAddr[1:0] != 2'b00);
        st_be   = 4'b1111;
        st_data = DWdata;
      end
      default: d_mis = 1'b1;
    endcase
  end

  // Memory port drive; all fields idle at zero when nothing is issued
  always_comb begin
    MemEn    = 1'b0;
    MemWe    = 4'b0000;
    MemAddr  = '0;
    MemWdata = '0;
    if (IGnt) begin
      MemEn   = 1'b1;
      MemAddr = IAddr & WORD_MASK;
    end else if (DGnt && !d_mis) begin
      MemEn   = 1'b1;
      MemAddr = DAddr & WORD_MASK;
      if (DWe) begin
        MemWe    = st_be;
        MemWdata = st_data;
      end
    end
  end

  // Last-grant bookkeeping
  always_comb begin
    last_gnt_nxt = last_gnt;
    if (DGnt)      last_gnt_nxt = SRC_D;
    else if (IGnt) last_gnt_nxt = SRC_I;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_gnt <= SRC_I;
    else        last_gnt <= last_gnt_nxt;
  end

  // Read tag pipeline: one entry per cycle, tail lines up with MemRdata
  assign push_vld = IGnt | (DGnt & ~d_mis & ~DWe);
  assign push_src = DGnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      tag_src <= '0;
    end else begin
      tag_vld[0] <= push_vld;
      tag_src[0] <= push_src;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_src[i] <= tag_src[i-1];
      end
    end
  end

  assign tail_vld = tag_vld[READ_LATENCY-1];
  assign tail_src = tag_src[READ_LATENCY-1];

  assign IRdValid = tail_vld & ~tail_src;
  assign DRdValid = tail_vld & tail_src;
  assign IRdData  = IRdValid ? MemRdata : i_hold;
  assign DRdData  = DRdValid ? MemRdata : d_hold;

  // Return-data hold and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_hold <= '0;
      d_hold <= '0;
      DErr   <= 1'b0;
    end else begin
      if (IRdValid) i_hold <= MemRdata;
      if (DRdValid) d_hold <= MemRdata;
      DErr <= DGnt & d_mis;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. A fixed-latency memory model returns an
// address-derived word. A reference model built from the arbitration, lane
// and tagging rules predicts the grants, the port fields, DErr and the routed
// responses in every cycle.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 2;
  localparam int unsigned AW  = 32;

  logic          clk;
  logic          rst_n;
  logic          IReq;
  logic [AW-1:0] IAddr;
  logic          IGnt;
  logic          IRdValid;
  logic [31:0]   IRdData;
  logic          DReq;
  logic          DWe;
  logic [AW-1:0] DAddr;
  logic [1:0]    DSize;
  logic [31:0]   DWdata;
  logic          DGnt;
  logic          DRdValid;
  logic [31:0]   DRdData;
  logic          DErr;
  logic          MemEn;
  logic [3:0]    MemWe;
  logic [AW-1:0] MemAddr;
  logic [31:0]   MemWdata;
  logic [31:0]   MemRdata;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem_port_arbiter #(.READ_LATENCY(LAT), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .IReq(IReq), .IAddr(IAddr), .IGnt(IGnt),
    .IRdValid(IRdValid), .IRdData(IRdData),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DSize(DSize), .DWdata(DWdata),
    .DGnt(DGnt), .DRdValid(DRdValid), .DRdData(DRdData), .DErr(DErr),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemRdata(MemRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Memory: samples the port at the enable edge, data valid LAT cycles later
  logic [31:0] mem_pipe [LAT];
  always @(posedge clk) begin
    mem_pipe[0] <= MemEn ? mem_word(MemAddr) : 32'h0BAD_0BAD;
    for (int i = 1; i < int'(LAT); i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign MemRdata = mem_pipe[LAT-1];

  // Reference model state
  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       rq[$];
  bit          m_last_d;
  bit          m_err;
  bit          m_known_i, m_known_d;
  logic [31:0] m_hold_i, m_hold_d;
  bit          g_i, g_d, m_gi, m_gd;

  task automatic model_clear();
    rq.delete();
    m_last_d  = 1'b0;
    m_err     = 1'b0;
    m_known_i = 1'b0;
    m_known_d = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: compare at the negedge, advance the model at the posedge
  task automatic step();
    bit          ei, ed, tie_d, mis, en, st, req_any;
    bit          exp_iv, exp_dv;
    logic [31:0] exp_data;
    int          n, off;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [AW-1:0] a;
    @(negedge clk);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tie_d = !m_last_d;
`else
    tie_d = 1'b1;
`endif
    ed = DReq && (!IReq || tie_d);
    ei = IReq && !ed;
    case (DSize)
      2'b00:   n = 1;
      2'b01:   n = 2;
      2'b11:   n = 4;
      default: n = 0;
    endcase
    off = int'(DAddr[1:0]);
    if (n == 0) mis = 1'b1;
    else        mis = (off % n) != 0;
    st      = ed && !mis && DWe;
    en      = ei || (ed && !mis);
    req_any = IReq || DReq;
    a       = ei ? IAddr : DAddr;
    a[1:0]  = 2'b00;
    we = '0;
    wd = '0;
    if (st) begin
      for (int k = 0; k < 4; k++) begin
        if (k >= off && k < off + n) we[3-k] = 1'b1;
        wd[31-8*k -: 8] = DWdata[8*(n-1-(k%n)) +: 8];
      end
    end

    chk("IGnt", IGnt, ei);
    chk("DGnt", DGnt, ed);
    chk("MemEn", MemEn, en);
    chk("MemWe", MemWe, we);
    if (en) chk("MemAddr", MemAddr, a);
    if (st) chk("MemWdata", MemWdata, wd);
    if (!req_any) begin
      chk("MemAddr_idle", MemAddr, '0);
      chk("MemWdata_idle", MemWdata, '0);
    end
    chk("DErr", DErr, m_err);

    exp_iv   = 1'b0;
    exp_dv   = 1'b0;
    exp_data = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_iv   = !rq[0].is_d;
      exp_dv   = rq[0].is_d;
      exp_data = rq[0].data;
      void'(rq.pop_front());
    end
    chk("IRdValid", IRdValid, exp_iv);
    chk("DRdValid", DRdValid, exp_dv);
    if (exp_iv) begin
      chk("IRdData", IRdData, exp_data);
      m_hold_i  = exp_data;
      m_known_i = 1'b1;
    end else if (m_known_i) begin
      chk("IRdData_hold", IRdData, m_hold_i);
    end
    if (exp_dv) begin
      chk("DRdData", DRdData, exp_data);
      m_hold_d  = exp_data;
      m_known_d = 1'b1;
    end else if (m_known_d) begin
      chk("DRdData_hold", DRdData, m_hold_d);
    end

    g_i  = IGnt;
    g_d  = DGnt;
    m_gi = ei;
    m_gd = ed;

    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_clear();
    end else begin
      m_err = ed && mis;
      if (ei || ed) m_last_d = ed;
      if (ei || (ed && !mis && !DWe))
        rq.push_back('{is_d: ed, data: mem_word(a), due: cyc - 1 + int'(LAT)});
    end
    #1;
  endtask

  task automatic idle(input int n);
    IReq = 1'b0;
    DReq = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic d_req(input bit we_i, input logic [AW-1:0] a, input logic [1:0] sz,
                       input logic [31:0] wd_i);
    DReq   = 1'b1;
    DWe    = we_i;
    DAddr  = a;
    DSize  = sz;
    DWdata = wd_i;
  endtask

  bit exp_seq [4];

  initial begin
    rst_n  = 1'b0;
    IReq   = 1'b0;
    IAddr  = '0;
    DReq   = 1'b0;
    DWe    = 1'b0;
    DAddr  = '0;
    DSize  = 2'b11;
    DWdata = '0;
    model_clear();
    step();
    step();
    rst_n = 1'b1;
    step();

    // I fetch at 0x100
    IReq  = 1'b1;
    IAddr = 32'h100;
    step();
    idle(LAT + 1);

    // Byte, half and word stores
    d_req(1'b1, 32'h203, 2'b00, 32'h0000_00AB);
    step();
    chk("byte_we", MemWe, 4'b0001);
    d_req(1'b1, 32'h202, 2'b01, 32'h0000_1234);
    step();
    d_req(1'b1, 32'h204, 2'b11, 32'hDEAD_BEEF);
    step();
    idle(1);

    // Misaligned half load, then illegal size, then an aligned byte load
    d_req(1'b0, 32'h101, 2'b01, 32'h0);
    step();
    idle(LAT + 1);
    d_req(1'b0, 32'h101, 2'b10, 32'h0);
    step();
    idle(LAT + 1);
    d_req(1'b0, 32'h103, 2'b00, 32'h0);
    step();
    idle(LAT + 1);

    // Last grant to I, then both requesters held for four cycles
    IReq  = 1'b1;
    IAddr = 32'h3F0;
    step();
    IAddr = 32'h400;
    d_req(1'b0, 32'h300, 2'b11, 32'h0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      chk("tie_seq_dgnt", g_d, exp_seq[i]);
      chk("tie_seq_ignt", g_i, !exp_seq[i]);
    end
    idle(LAT + 2);

    // Two reads in flight, reset one cycle after the second grant
    IReq  = 1'b1;
    IAddr = 32'h500;
    step();
    IReq = 1'b0;
    d_req(1'b0, 32'h504, 2'b11, 32'h0);
    step();
    DReq  = 1'b0;
    rst_n = 1'b0;
    model_clear();
    step();
    step();
    rst_n = 1'b1;
    idle(LAT + 2);
    IReq  = 1'b1;
    IAddr = 32'h600;
    d_req(1'b0, 32'h604, 2'b11, 32'h0);
    step();
    chk("post_reset_tie_d", g_d, 1'b1);
    idle(LAT + 2);

    // Random traffic; an ungranted request keeps its fields
    for (int c = 0; c < 400; c++) begin
      if (!IReq || m_gi) begin
        IReq  = ($urandom_range(0, 2) != 0);
        IAddr = 32'h1000 + AW'($urandom_range(0, 255));
      end
      if (!DReq || m_gd) begin
        DReq   = ($urandom_range(0, 2) != 0);
        DWe    = $urandom_range(0, 1) != 0;
        DSize  = 2'($urandom_range(0, 3));
        DAddr  = 32'h2000 + AW'($urandom_range(0, 255));
        DWdata = $urandom;
      end
      step();
    end
    idle(LAT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency, big-endian word memory between two requesters: instruction fetch (I) and data load/store (D).
- Per cycle it grants at most one request and drives the memory port.
- For stores, it generates byte write enables and lane-replicated write data from size and address.
- It tags every read in flight and routes the returned word to the requester that issued it.
- Returned D words are raw 32-bit lines; load extraction and sign handling happen downstream in the writeback stage.

Parameters:
- READ_LATENCY, 2: cycles from the memory enable edge to MemRdata being valid (1..4).
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IReq  in  1  instruction read request.
- IAddr  in  ADDR_W  instruction byte address; bits [1:0] ignored.
- IGnt  out  1  I request accepted this cycle.
- IRdValid  out  1  IRdData valid.
- IRdData  out  32  returned instruction word.
- DReq  in  1  data request.
- DWe  in  1  1 = store, 0 = load.
- DAddr  in  ADDR_W  data byte address.
- DSize  in  2  00 = byte, 01 = half, 11 = word, 10 = illegal.
- DWdata  in  32  store data, right-justified.
- DGnt  out  1  D request accepted this cycle.
- DRdValid  out  1  DRdData valid.
- DRdData  out  32  returned raw data word.
- DErr  out  1  one-cycle pulse: misaligned or illegal D request was dropped.
- MemEn  out  1  memory access this cycle.
- MemWe  out  4  byte write enables; bit 3 = bits [31:24] = lowest address.
- MemAddr  out  ADDR_W  word-aligned address ([1:0] = 0).
- MemWdata  out  32  lane-replicated store data.
- MemRdata  in  32  memory read data.

Behaviour:
- Reset (async assert, sync release):
  - IRdValid, DRdValid, DErr, tag pipeline valid bits = 0.
  - LastGnt = I, so D wins the first tie.
  - Grants and memory outputs are combinational and therefore 0 while no request is present.
  - Reset mid-operation discards all in-flight reads; no RdValid fires for them after release.
- Grant (combinational from requests and LastGnt):
  - Only one requester asserting: it is granted.
  - Both asserting: arbitration per the optional feature below.
  - An ungranted requester must hold its request and fields stable until granted.
  - LastGnt updates on every grant edge.
- Memory drive in the grant cycle:
  - MemEn = 1.
  - MemAddr = {addr[ADDR_W-1:2], 2'b00}.
  - For I requests and D loads, MemWe = 0000.
- Store mapping (D with DWe = 1):
  - Byte: MemWe = 1000 >> addr[1:0]; MemWdata = DWdata[7:0] replicated into all four lanes.
  - Half: MemWe = 1100 when addr[1] = 0, 0011 when addr[1] = 1; MemWdata = {DWdata[15:0], DWdata[15:0]}.
  - Word: MemWe = 1111; MemWdata = DWdata.
- Alignment check (D only):
  - Half with addr[0] = 1, word with addr[1:0] != 0, or DSize = 10 is misaligned.
  - A misaligned request is still granted (DGnt = 1), but MemEn = 0.
  - DErr pulses the next cycle; no read tag is issued.
- Read tagging:
  - Each granted read pushes {valid = 1, src} into a READ_LATENCY-deep shift register.
  - Stores and idle cycles push valid = 0.
  - When the tail entry is valid, the matching xRdValid is asserted for exactly one cycle, with xRdData = MemRdata.
  - Responses return strictly in issue order, exactly READ_LATENCY cycles after the grant edge.
  - Back-to-back reads are allowed every cycle, so throughput is 1 per cycle.
- Unused RdData outputs are held at their last value; consumers qualify with RdValid.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN
- Defined: on a tie, grant the requester not in LastGnt (alternates I/D).
- Undefined: fixed priority, D always beats I; LastGnt is still maintained but unused for arbitration.

Test Plan:
- Reset, then IReq with IAddr = 0x100, READ_LATENCY = 2 → IGnt same cycle, MemEn = 1, MemAddr = 0x100, MemWe = 0; IRdValid asserted 2 cycles later with IRdData = MemRdata; DRdValid stays 0.
- D byte store, DAddr = 0x203, DWdata = 0x000000AB → MemAddr = 0x200, MemWe = 0001, MemWdata = 0xABABABAB.
- D half store, DAddr = 0x202, DWdata = 0x1234 → MemWe = 0011, MemWdata = 0x12341234.
- D word store, DAddr = 0x204 → MemWe = 1111.
- D half load, DAddr = 0x101 → DGnt = 1, MemEn = 0, DErr pulses once the next cycle, no DRdValid.
- Same stimulus with DSize = 10 → identical response.
- IReq and DReq held 4 cycles:
  - Without the macro: D, D, D, D, with I starved.
  - With MEM_ARB_ROUND_ROBIN_EN: D, I, D, I.
  - In both cases, responses are routed to the issuing source, in order, 1 per cycle.
- Issue 2 reads, then drop rst_n 1 cycle after the second grant → after release, no IRdValid or DRdValid fires for either read, and LastGnt is back to I.
